pwm_duty_meter: RTL and testbench
=================================

Name: pwm_duty_meter

Overview:
- Receive-side counterpart of the team's PWM/breathing-light drivers. Measures an external or looped-back PWM waveform and reports its period, high time and 8-bit duty cycle (0..255 scale, matching the driver's duty register).
- Used to close the loop on LED brightness generation and to self-test PWM outputs on the board.
- Contains an input synchronizer, edge detector, measurement FSM, timeout/stuck detection and an 8-cycle sequential divider.

Parameters:
CNT_W, 32, width of period/high-time counters and outputs
TIMEOUT, 20000000, cycles without an input edge before the line is declared stuck; must be >= 16 and <= 2^CNT_W-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pwm_in  in  1  asynchronous PWM input
duty_out  out  8  floor(high*256/period), stuck-high 255, stuck-low 0
period_out  out  CNT_W  last measured period in clk cycles, 0 when stuck
high_out  out  CNT_W  last measured high time in clk cycles, 0 when stuck
valid  out  1  one-cycle pulse: new result on duty/period/high/stuck
stuck  out  1  level: last result came from timeout
overrun  out  1  one-cycle pulse: completed period discarded because divider busy

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: all outputs 0, synchronizer flops 0, FSM IDLE, divider idle, counter 0. Reset mid-measurement or mid-divide aborts with no valid pulse.
- Input path: 2-FF synchronizer, then a prev register.
  - rise = s & ~prev; fall = ~s & prev.
  - A pwm_in transition is detected 3 clocks later.
- Counter cnt saturates at 2^CNT_W-1.
  - On rise: cnt <= 1.
  - Otherwise: cnt <= cnt+1.
- FSM states: IDLE, MEAS_HIGH, MEAS_LOW.
  - IDLE: rise -> MEAS_HIGH. fall -> cnt <= 0, stay.
  - MEAS_HIGH: fall -> high_lat <= cnt, go to MEAS_LOW.
  - MEAS_LOW: rise -> period_lat <= cnt, launch divider (or overrun), go to MEAS_HIGH. This back-to-back measurement restarts with cnt=1.
- Timeout: cnt == TIMEOUT with no edge in that cycle, in any state.
  - Effect: valid=1, stuck=1, period_out=0, high_out=0, duty_out = s ? 255 : 0. FSM -> IDLE.
  - Fires once only. cnt holds at TIMEOUT until the next edge.
  - An in-flight divide is cancelled and its result dropped.
- Divider (restoring, CNT_W+1-bit remainder):
  - Load on the closing rise (cycle T): r <= high_lat value, d <= period.
  - 8 iterations in T+1..T+8. Each iteration: r <<= 1; if r >= d then r -= d and q bit = 1, else q bit = 0. Quotient is filled MSB first.
  - In T+9: duty_out, period_out, high_out updated; valid=1; stuck=0.
  - high < period always holds, so the quotient fits 8 bits without saturation.
- Divider busy while a new period closes: that result is dropped, overrun pulses for 1 cycle, and measurement continues normally. This only happens for periods < 9 cycles.
- Simultaneous timeout and divider completion: timeout wins.
- Result outputs hold their value between valid pulses.

Decomposition:
- Shared package: FSM state enum (IDLE/MEAS_HIGH/MEAS_LOW), DUTY_W=8 constant, duty full-scale 255 constant. The PWM driver uses the same constants.
- One natural sub-module: pwm_duty_div, the 8-iteration restoring divider with start/busy/done and a cancel input.
- Synchronizer and edge detect stay inline.

Test Plan:
- pwm_in period 100 cycles, high 25 -> duty_out 64, period_out 100, high_out 25, valid every 100 cycles, stuck 0, overrun 0.
- Period 100, high 50 -> 128. High 99 -> 253. High 1 -> 2. Check the valid pulse is exactly 9 clocks after the internal closing rise.
- pwm_in held high from reset, TIMEOUT=1000 -> single valid ~1000 cycles after reset: duty 255, stuck 1, period 0. No further valid pulses. Repeat held low -> duty 0.
- Period 6, high 3 -> every other period reports duty 128; overrun pulses for the alternating dropped periods.
- Assert rst_n low during divide cycle T+4 -> no valid; all outputs 0 immediately (asynchronous). After release with 100/25 input, first valid after a full period: duty 64.
- 100/25 input then stop toggling low, TIMEOUT=1000 -> stuck result duty 0. On restart at 100/75 -> first valid duty 192, stuck cleared to 0.

Source files
------------

// File: rtl/pwm_duty_meter_pkg.sv
// rtl/pwm_duty_meter_pkg.sv - shared duty constants and measurement FSM state type
package pwm_duty_meter_pkg;

    localparam int                DUTY_W    = 8;
    localparam logic [DUTY_W-1:0] DUTY_FULL = {DUTY_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MEAS_HIGH = 2'd1,
        ST_MEAS_LOW  = 2'd2
    } meas_state_e;

endpackage

// File: rtl/pwm_duty_div.sv
// rtl/pwm_duty_div.sv - 8-iteration restoring divider producing floor(num*256/den)
// Ports: start loads num/den (requires num < den); cancel aborts and suppresses done;
// busy is high during the iterations; done pulses with quot during the last iteration.
module pwm_duty_div
    import pwm_duty_meter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cancel,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quot
);

    localparam int ITER_W = $clog2(DUTY_W);

    logic [CNT_W:0]      rem_q, rem_d;
    logic [CNT_W-1:0]    den_q, den_d;
    logic [DUTY_W-1:0]   quot_q, quot_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                busy_q, busy_d;

    logic [CNT_W:0]      rem_sh;
    logic [CNT_W:0]      den_ext;
    logic                ge;
    logic                last_iter;
    logic [DUTY_W-1:0]   quot_nx;

    always_comb begin
        // rem < den always, so the shifted remainder fits in CNT_W+1 bits
        rem_sh    = rem_q << 1;
        den_ext   = {1'b0, den_q};
        ge        = (rem_sh >= den_ext);
        quot_nx   = (quot_q << 1) | {{(DUTY_W-1){1'b0}}, ge};
        last_iter = (iter_q == ITER_W'(DUTY_W - 1));

        rem_d  = rem_q;
        den_d  = den_q;
        quot_d = quot_q;
        iter_d = iter_q;
        busy_d = busy_q;

        if (cancel) begin
            busy_d = 1'b0;
        end else if (start) begin
            rem_d  = {1'b0, num};
            den_d  = den;
            quot_d = '0;
            iter_d = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = ge ? (rem_sh - den_ext) : rem_sh;
            quot_d = quot_nx;
            iter_d = iter_q + ITER_W'(1);
            if (last_iter) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            quot_q <= quot_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q & last_iter & ~cancel;
    assign quot = quot_nx;

endmodule

// File: rtl/pwm_duty_meter.sv
// rtl/pwm_duty_meter.sv - measures period, high time and 8-bit duty of a PWM input
// Ports: pwm_in asynchronous input; duty_out/period_out/high_out hold the last result;
// valid pulses per result; stuck marks a timeout result; overrun pulses per dropped period.
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter int unsigned TIMEOUT = 20000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic [CNT_W-1:0]  period_out,
    output logic [CNT_W-1:0]  high_out,
    output logic              valid,
    output logic              stuck,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic              s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    meas_state_e       state_q, state_d;
    logic              fired_q, fired_d;
    logic [CNT_W-1:0]  high_lat_q, high_lat_d;
    logic [CNT_W-1:0]  res_period_q, res_period_d;
    logic [CNT_W-1:0]  res_high_q, res_high_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              valid_q, valid_d;
    logic              stuck_q, stuck_d;
    logic              overrun_q, overrun_d;

    logic              rise, fall, at_limit, timeout, launch;
    logic              div_start, div_busy, div_done;
    logic [DUTY_W-1:0] div_quot;

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (div_start),
        .cancel (timeout),
        .num    (high_lat_q),
        .den    (cnt_q),
        .busy   (div_busy),
        .done   (div_done),
        .quot   (div_quot)
    );

    always_comb begin
        s1_d   = pwm_in;
        s2_d   = s1_q;
        prev_d = s2_q;
        rise   = s2_q & ~prev_q;
        fall   = ~s2_q & prev_q;

        // >= rather than == so a fall landing exactly on the limit cannot
        // let the counter run past the timeout without ever firing
        at_limit = (cnt_q >= TIMEOUT_C);
        timeout  = at_limit & ~rise & ~fall & ~fired_q;

        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (fall && state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (at_limit && !fall) begin
            cnt_d = cnt_q;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // timeout reports once per quiet stretch; any edge re-arms it
        if (rise || fall) begin
            fired_d = 1'b0;
        end else if (timeout) begin
            fired_d = 1'b1;
        end else begin
            fired_d = fired_q;
        end

        state_d    = state_q;
        high_lat_d = high_lat_q;
        launch     = 1'b0;
        if (timeout) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) state_d = ST_MEAS_HIGH;
                end
                ST_MEAS_HIGH: begin
                    if (fall) begin
                        high_lat_d = cnt_q;
                        state_d    = ST_MEAS_LOW;
                    end
                end
                ST_MEAS_LOW: begin
                    if (rise) begin
                        launch  = 1'b1;
                        state_d = ST_MEAS_HIGH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        div_start = launch & ~div_busy;
        overrun_d = launch & div_busy;

        // period/high travel alongside the divide so a later fall cannot
        // corrupt the result being computed
        res_period_d = res_period_q;
        res_high_d   = res_high_q;
        if (div_start) begin
            res_period_d = cnt_q;
            res_high_d   = high_lat_q;
        end

        duty_d   = duty_q;
        period_d = period_q;
        high_d   = high_q;
        stuck_d  = stuck_q;
        valid_d  = 1'b0;
        if (timeout) begin
            valid_d  = 1'b1;
            stuck_d  = 1'b1;
            period_d = '0;
            high_d   = '0;
            duty_d   = s2_q ? DUTY_FULL : '0;
        end else if (div_done) begin
            valid_d  = 1'b1;
            stuck_d  = 1'b0;
            period_d = res_period_q;
            high_d   = res_high_q;
            duty_d   = div_quot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            fired_q      <= 1'b0;
            high_lat_q   <= '0;
            res_period_q <= '0;
            res_high_q   <= '0;
            duty_q       <= '0;
            period_q     <= '0;
            high_q       <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            fired_q      <= fired_d;
            high_lat_q   <= high_lat_d;
            res_period_q <= res_period_d;
            res_high_q   <= res_high_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            high_q       <= high_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
            overrun_q    <= overrun_d;
        end
    end

    assign duty_out   = duty_q;
    assign period_out = period_q;
    assign high_out   = high_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb/tb_pwm_duty_meter.sv - self-checking bench for pwm_duty_meter
module tb_pwm_duty_meter;

    localparam int CNT_W    = 32;
    localparam int TMO      = 1000;
    localparam int SYNC_LAT = 2;
    localparam int RES_LAT  = SYNC_LAT + 9;
    localparam int DIV_GAP  = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [7:0]       duty_out;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             valid, stuck, overrun;

    pwm_duty_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .stuck      (stuck),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   duty;
        int   period;
        int   high;
        logic stuck;
        int   exp_cyc;
        int   tol;
    } exp_t;

    typedef struct {
        int high;
        int period;
        int nper;
        int exp_duty;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int m_open = 0;
    int m_open_cyc = 0;
    int m_high = 0;
    int m_last_acc = -1000;
    int m_exp_ovr = 0;
    int ovr_seen = 0;
    int last_duty = -1;
    int last_period = -1;
    int last_high = -1;
    int last_stuck = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int duty, input int period, input int high,
                            input logic stk, input int at, input int tol);
        exp_t e;
        e.duty = duty; e.period = period; e.high = high;
        e.stuck = stk; e.exp_cyc = at; e.tol = tol;
        exp_q.push_back(e);
    endtask

    // Reference model: a rise closes the open period; the divider accepts a
    // close only if the previous accepted close is at least DIV_GAP cycles old.
    task automatic model_rise();
        int per;
        if (m_open != 0) begin
            per = cyc - m_open_cyc;
            if (cyc - m_last_acc >= DIV_GAP) begin
                push_exp((m_high * 256) / per, per, m_high, 1'b0, cyc + RES_LAT, 0);
                m_last_acc = cyc;
            end else begin
                m_exp_ovr++;
            end
        end
        m_open = 1;
        m_open_cyc = cyc;
        m_high = 0;
    endtask

    task automatic model_fall();
        if (m_open != 0) m_high = cyc - m_open_cyc;
    endtask

    task automatic drive_level(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            if (v !== pwm_in) begin
                if (v) model_rise();
                else   model_fall();
            end
            pwm_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_period(input int h, input int p);
        drive_level(1'b1, h);
        drive_level(1'b0, p - h);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            drive_level(pwm_in, 1);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset(input logic level);
        rst_n = 1'b0;
        pwm_in = level;
        #1;
        check("rst_duty", duty_out, 0);
        check("rst_period", period_out, 0);
        check("rst_high", high_out, 0);
        check("rst_valid", valid, 0);
        check("rst_stuck", stuck, 0);
        check("rst_overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        m_open = 0;
        m_last_acc = -1000;
        rst_n = 1'b1;
        if (level) model_rise();
    endtask

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid at cycle %0d duty %0d stuck %0d, required none",
                         cyc, duty_out, stuck);
            end else begin
                mon_e = exp_q.pop_front();
                check("duty", duty_out, mon_e.duty);
                check("period", period_out, mon_e.period);
                check("high", high_out, mon_e.high);
                check("stuck", stuck, mon_e.stuck);
                checks++;
                if (cyc < mon_e.exp_cyc - mon_e.tol || cyc > mon_e.exp_cyc + mon_e.tol) begin
                    errors++;
                    $display("FAIL valid_time: got cycle %0d required %0d +/- %0d",
                             cyc, mon_e.exp_cyc, mon_e.tol);
                end
            end
            last_duty = duty_out;
            last_period = period_out;
            last_high = high_out;
            last_stuck = stuck;
        end
        if (rst_n && overrun) ovr_seen++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   c0, cf, p, h;

        vecs[0] = '{25, 100, 3, 64};
        vecs[1] = '{50, 100, 3, 128};
        vecs[2] = '{99, 100, 3, 253};
        vecs[3] = '{1, 100, 3, 2};
        vecs[4] = '{8, 9, 4, 227};
        vecs[5] = '{1, 9, 4, 28};
        vecs[6] = '{7, 13, 4, 137};
        vecs[7] = '{3, 6, 10, 128};

        @(posedge clk);
        #1;
        do_reset(1'b0);

        // table: each entry's last reported result must be its own period
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].nper; k++) drive_period(vecs[i].high, vecs[i].period);
            drain(60);
            check("tbl_duty", last_duty, vecs[i].exp_duty);
            check("tbl_period", last_period, vecs[i].period);
            check("tbl_high", last_high, vecs[i].high);
        end
        check("tbl_overrun_count", ovr_seen, m_exp_ovr);
        check("tbl_overrun_seen", ovr_seen > 0, 1);

        // randomized periods, all long enough for the divider
        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(150, DIV_GAP);
            h = $urandom_range(p - 1, 1);
            drive_period(h, p);
        end
        drive_period(25, 100);
        drive_period(25, 100);
        drain(60);
        check("rand_overrun_count", ovr_seen, m_exp_ovr);

        // reset during divide cycle T+4 of an in-flight result
        pwm_in = 1'b1;
        c0 = cyc;
        while (cyc < c0 + SYNC_LAT + 4) begin
            @(posedge clk);
            #1;
        end
        #2;
        check("hold_duty", duty_out, 64);
        check("hold_period", period_out, 100);
        check("hold_high", high_out, 25);
        check("middiv_valid", valid, 0);
        rst_n = 1'b0;
        #1;
        check("async_duty", duty_out, 0);
        check("async_period", period_out, 0);
        check("async_high", high_out, 0);
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) drive_period(25, 100);
        drain(60);
        check("post_rst_duty", last_duty, 64);

        // input stops low -> stuck-low result, then restart at 75%
        push_exp(0, 0, 0, 1'b1, m_open_cyc + TMO + 3, 2);
        m_open = 0;
        drive_level(1'b0, TMO + 100);
        drain(60);
        check("stop_low_stuck", stuck, 1);
        check("stop_low_duty", duty_out, 0);
        for (int k = 0; k < 3; k++) drive_period(75, 100);
        drain(60);
        check("restart_duty", last_duty, 192);
        check("restart_stuck", stuck, 0);

        // held high from reset: one stuck-high result, then stuck-low after the fall
        do_reset(1'b1);
        push_exp(255, 0, 0, 1'b1, m_open_cyc + TMO + 3, 2);
        m_open = 0;
        drive_level(1'b1, 3 * TMO);
        check("held_high_stuck", stuck, 1);
        check("held_high_duty", duty_out, 255);
        cf = cyc;
        push_exp(0, 0, 0, 1'b1, cf + TMO + 4, 2);
        drive_level(1'b0, TMO + 200);
        drain(60);

        // held low from reset
        do_reset(1'b0);
        push_exp(0, 0, 0, 1'b1, cyc + TMO + 1, 2);
        drive_level(1'b0, 2 * TMO + 200);
        drain(60);
        check("held_low_stuck", stuck, 1);
        check("held_low_period", period_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
